// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the TX control
// path) and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a registered
// falling-edge detector. Every flop resets to the idle-high line level so
// that leaving reset never looks like a start edge.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_serial,
    output logic line_s,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic fall_q, fall_d;

    // Next values: shift the line through the synchronizer and flag 1->0 edges.
    always_comb begin
        meta_d = rx_serial;
        sync_d = meta_q;
        prev_d = sync_q;
        fall_d = prev_q & ~sync_q;
    end

    // Synchronizer, previous-value and edge flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign line_s = sync_q;
    // The edge is held in a flop so that an edge seen during the final STOP
    // cycle is still presented once the FSM is back in IDLE.
    assign fall   = fall_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_BITS data bits LSB-first, parity, stop.
// Bits are sampled mid-bit using an external oversampling tick.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line idle, waiting for a falling edge; ticks ignored
//   START  | validate start bit at its middle; high there = glitch
//   DATA   | sample one data bit every OVERSAMPLE ticks
//   PARITY | sample parity bit and latch the parity check result
//   STOP   | sample stop bit, publish data/flags, pulse rx_valid
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic line_s;
    logic fall;

    uart_rx_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .line_s    (line_s),
        .fall      (fall)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic mid_tick;
    logic end_tick;

    assign mid_tick = baud_tick && (cnt_q == CNT_MID);
    assign end_tick = baud_tick && (cnt_q == CNT_END);

    // Next-state logic, shift register, parity capture and frame publication.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (mid_tick) begin
                    state_d = line_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (end_tick) begin
                    shift_d = {line_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (end_tick) begin
                    perr_d  = (^shift_q) ^ line_s ^ PARITY_ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (end_tick) begin
                    rx_data_d    = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ~line_s;
                    rx_valid_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample counter: restarts on every state change, counts ticks outside IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (baud_tick && (state_q != IDLE)) begin
            cnt_d = (cnt_q == CNT_END) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule : uart_rx
